// File: rtl/sample_buf_pkg.sv
// Shared types and helpers for the sample capture buffer.
package sample_buf_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_PRE       = 3'd1,
    S_WAIT_TRIG = 3'd2,
    S_POST      = 3'd3,
    S_DONE      = 3'd4,
    S_READ      = 3'd5
  } cap_state_t;

  // Limit post-trigger length so pre + trigger + post never exceeds the RAM depth.
  function automatic int unsigned clamp_post_len(input int unsigned pre_len,
                                                 input int unsigned post_len,
                                                 input int unsigned addr_w);
    int unsigned depth;
    depth = 32'd1 << addr_w;
    if (pre_len + post_len >= depth) return depth - 32'd1 - pre_len;
    return post_len;
  endfunction

endpackage

// File: rtl/sample_bram_sdp.sv
// One-clock simple dual-port RAM: one write port, one registered read port.
module sample_bram_sdp #(
  parameter int unsigned DATA_W = 560,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/sample_capture_buffer.sv
// Circular pre/post-trigger capture buffer with valid/ready readout, oldest sample first.
module sample_capture_buffer
  import sample_buf_pkg::*;
#(
  parameter int unsigned DATA_W = 560,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arm,
  input  logic [ADDR_W-1:0] pre_len,
  input  logic [ADDR_W-1:0] post_len,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              trig,
  input  logic              rd_start,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              triggered,
  output logic              done,
  output logic [ADDR_W-1:0] trig_addr
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  cap_state_t state, state_nxt;

  logic [ADDR_W-1:0] wr_ptr, rd_ptr, rd_addr, rd_base;
  logic [ADDR_W-1:0] pre_len_q, post_eff_q, post_eff, pre_cnt, post_cnt;
  logic [CNT_W-1:0]  rd_rem, rd_total, rd_rem_cur;
  logic              capturing, arm_ok, wr_en, trig_hit, start_rd, rd_issue;
  logic              rd_pend, rd_pend_last, pop;
  logic [2:0]        occ;
  logic [DATA_W-1:0] ram_q, buf0_data, buf1_data;
  logic              buf0_last, buf1_last;
  logic [1:0]        buf_cnt;

  assign capturing = (state == S_PRE) || (state == S_WAIT_TRIG) || (state == S_POST);
  assign arm_ok    = arm && (state != S_READ);
  assign wr_en     = capturing && in_valid;
  assign trig_hit  = (state == S_WAIT_TRIG) && in_valid && trig && !arm;
  assign post_eff  = ADDR_W'(clamp_post_len(32'(pre_len), 32'(post_len), ADDR_W));

  assign rd_base    = trig_addr - pre_len_q;
  assign rd_total   = {1'b0, pre_len_q} + {1'b0, post_eff_q} + CNT_W'(1);
  assign start_rd   = (state == S_DONE) && rd_start && !arm;
  assign rd_rem_cur = start_rd ? rd_total : rd_rem;
  assign rd_addr    = (state == S_DONE) ? rd_base : rd_ptr;

  // First read is issued from DONE so data reaches the skid buffer two cycles after rd_start;
  // later reads issue only while buffered + in-flight words stay below two.
  assign pop      = out_valid && out_ready;
  assign occ      = 3'(buf_cnt) + 3'(rd_pend) - 3'(pop);
  assign rd_issue = start_rd || ((state == S_READ) && (rd_rem != '0) && (occ < 3'd2));

  sample_bram_sdp #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk    (clk),
    .wr_en  (wr_en),
    .wr_addr(wr_ptr),
    .wr_data(in_data),
    .rd_en  (rd_issue),
    .rd_addr(rd_addr),
    .rd_data(ram_q)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: ;
      S_PRE: begin
        if (pre_cnt == pre_len_q)
          state_nxt = S_WAIT_TRIG;
        else if (in_valid && (pre_cnt + ADDR_W'(1) == pre_len_q))
          state_nxt = S_WAIT_TRIG;
      end
      S_WAIT_TRIG: begin
        if (trig_hit) state_nxt = (post_eff_q == '0) ? S_DONE : S_POST;
      end
      S_POST: begin
        if (in_valid && (post_cnt + ADDR_W'(1) == post_eff_q)) state_nxt = S_DONE;
      end
      S_DONE: begin
        if (rd_start) state_nxt = S_READ;
      end
      S_READ: begin
        if (pop && out_last) state_nxt = S_DONE;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (arm_ok) state_nxt = S_PRE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      pre_len_q    <= '0;
      post_eff_q   <= '0;
      pre_cnt      <= '0;
      post_cnt     <= '0;
      trig_addr    <= '0;
      triggered    <= 1'b0;
      rd_ptr       <= '0;
      rd_rem       <= '0;
      rd_pend      <= 1'b0;
      rd_pend_last <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (arm_ok) begin
        pre_len_q  <= pre_len;
        post_eff_q <= post_eff;
        triggered  <= 1'b0;
        pre_cnt    <= '0;
        post_cnt   <= '0;
      end else begin
        if ((state == S_PRE) && in_valid && (pre_cnt != pre_len_q))
          pre_cnt <= pre_cnt + ADDR_W'(1);
        if (trig_hit) begin
          trig_addr <= wr_ptr;
          triggered <= 1'b1;
          post_cnt  <= '0;
        end
        if ((state == S_POST) && in_valid) post_cnt <= post_cnt + ADDR_W'(1);
      end
      if (rd_issue) begin
        rd_ptr <= rd_addr + ADDR_W'(1);
        rd_rem <= rd_rem_cur - CNT_W'(1);
      end
      rd_pend      <= rd_issue;
      rd_pend_last <= rd_issue && (rd_rem_cur == CNT_W'(1));
    end
  end

  // Two-entry skid buffer: buf0 is the head presented on the output.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_cnt   <= '0;
      buf0_data <= '0;
      buf1_data <= '0;
      buf0_last <= 1'b0;
      buf1_last <= 1'b0;
    end else begin
      case ({rd_pend, pop})
        2'b10: begin
          if (buf_cnt == 2'd0) begin
            buf0_data <= ram_q;
            buf0_last <= rd_pend_last;
          end else begin
            buf1_data <= ram_q;
            buf1_last <= rd_pend_last;
          end
          buf_cnt <= buf_cnt + 2'd1;
        end
        2'b01: begin
          buf0_data <= buf1_data;
          buf0_last <= buf1_last;
          buf_cnt   <= buf_cnt - 2'd1;
        end
        2'b11: begin
          if (buf_cnt == 2'd1) begin
            buf0_data <= ram_q;
            buf0_last <= rd_pend_last;
          end else begin
            buf0_data <= buf1_data;
            buf0_last <= buf1_last;
            buf1_data <= ram_q;
            buf1_last <= rd_pend_last;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_valid = (buf_cnt != 2'd0);
  assign out_data  = buf0_data;
  assign out_last  = out_valid && buf0_last;
  assign busy      = capturing;
  assign done      = (state == S_DONE);

endmodule

// File: tb/tb_sample_capture_buffer.sv
// Directed bench for sample_capture_buffer with DATA_W=16, ADDR_W=4 (16-entry ring).
module tb_sample_capture_buffer;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 4;

  logic          clk = 1'b0;
  logic          rst, arm, in_valid, trig, rd_start, out_ready;
  logic [AW-1:0] pre_len, post_len;
  logic [DW-1:0] in_data;
  logic          out_valid, out_last, busy, triggered, done;
  logic [DW-1:0] out_data;
  logic [AW-1:0] trig_addr;

  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] dcnt   = '0;

  sample_capture_buffer #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .arm(arm), .pre_len(pre_len), .post_len(post_len),
    .in_valid(in_valid), .in_data(in_data), .trig(trig), .rd_start(rd_start),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .triggered(triggered), .done(done),
    .trig_addr(trig_addr)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic t);
    in_valid = 1'b1;
    in_data  = dcnt;
    trig     = t;
    tick();
    in_valid = 1'b0;
    trig     = 1'b0;
    dcnt     = dcnt + 16'd1;
  endtask

  task automatic do_arm(input logic [AW-1:0] pre, input logic [AW-1:0] post);
    arm      = 1'b1;
    pre_len  = pre;
    post_len = post;
    tick();
    arm = 1'b0;
  endtask

  task automatic readout(input logic [DW-1:0] first, input int n, input bit rnd,
                         input bit timing, input bit arm_mid);
    int            got;
    int            cyc;
    logic [DW-1:0] exp;
    logic          rdy;
    logic          held;
    logic [DW-1:0] held_data;
    got  = 0;
    cyc  = 0;
    exp  = first;
    held = 1'b0;
    held_data = '0;
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    if (timing) chk("first_lat0", 32'(out_valid), 32'd0);
    while (got < n && cyc < 300) begin
      rdy       = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      out_ready = rdy;
      arm       = arm_mid && (cyc == 2);
      pre_len   = 4'd5;
      post_len  = 4'd5;
      if (timing && cyc >= 1) chk("sustain_valid", 32'(out_valid), 32'd1);
      if (held) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_data", 32'(out_data), 32'(held_data));
      end
      if (out_valid && rdy) begin
        chk("rd_data", 32'(out_data), 32'(exp));
        chk("rd_last", 32'(out_last), 32'(got == n - 1));
        exp = exp + 16'd1;
        got++;
      end
      held      = out_valid && !rdy;
      held_data = out_data;
      tick();
      cyc++;
    end
    arm       = 1'b0;
    out_ready = 1'b0;
    chk("rd_count", 32'(got), 32'(n));
    if (timing) chk("rd_cycles", 32'(cyc), 32'(n + 1));
    chk("rd_end_valid", 32'(out_valid), 32'd0);
    chk("rd_end_done", 32'(done), 32'd1);
  endtask

  initial begin
    rst = 1'b1; arm = 1'b0; in_valid = 1'b0; trig = 1'b0; rd_start = 1'b0;
    out_ready = 1'b0; pre_len = '0; post_len = '0; in_data = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // reset values and idle behaviour
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_trig", 32'(triggered), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_taddr", 32'(trig_addr), 32'd0);
    chk("rst_ovalid", 32'(out_valid), 32'd0);
    chk("rst_odata", 32'(out_data), 32'd0);
    chk("rst_olast", 32'(out_last), 32'd0);
    rd_start = 1'b1; in_valid = 1'b1; trig = 1'b1; in_data = 16'hdead;
    tick();
    rd_start = 1'b0; in_valid = 1'b0; trig = 1'b0;
    tick();
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_done", 32'(done), 32'd0);
    chk("idle_trig", 32'(triggered), 32'd0);
    chk("idle_ovalid", 32'(out_valid), 32'd0);

    // pre=3 post=4: samples 0..2 pre, trig in PRE ignored, trigger on data 5 at addr 5
    do_arm(4'd3, 4'd4);
    chk("arm_busy", 32'(busy), 32'd1);
    send(1'b0);
    send(1'b1);
    chk("pre_trig_ign", 32'(triggered), 32'd0);
    send(1'b0);
    send(1'b0);
    send(1'b0);
    send(1'b1);
    chk("t1_triggered", 32'(triggered), 32'd1);
    chk("t1_taddr", 32'(trig_addr), 32'd5);
    repeat (3) send(1'b0);
    chk("t1_not_done", 32'(done), 32'd0);
    send(1'b0);
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_busy", 32'(busy), 32'd0);
    readout(16'd2, 8, 1'b0, 1'b1, 1'b0);
    readout(16'd2, 8, 1'b1, 1'b0, 1'b0);

    // pre=10 post=10 clamps post to 5; wr_ptr starts at 10 so the window wraps
    do_arm(4'd10, 4'd10);
    repeat (22) send(1'b0);
    chk("t2_not_trig", 32'(triggered), 32'd0);
    send(1'b1);
    chk("t2_taddr", 32'(trig_addr), 32'd0);
    repeat (4) send(1'b0);
    chk("t2_not_done", 32'(done), 32'd0);
    send(1'b0);
    chk("t2_done", 32'(done), 32'd1);
    readout(16'd22, 16, 1'b0, 1'b1, 1'b0);
    readout(16'd22, 16, 1'b1, 1'b0, 1'b0);

    // pre=0 post=0: trigger on first sample in WAIT_TRIG, single-word readout
    do_arm(4'd0, 4'd0);
    tick();
    chk("t3_busy", 32'(busy), 32'd1);
    send(1'b1);
    chk("t3_done", 32'(done), 32'd1);
    chk("t3_taddr", 32'(trig_addr), 32'd6);
    readout(16'd38, 1, 1'b0, 1'b1, 1'b0);

    // reset mid-POST
    do_arm(4'd1, 4'd3);
    send(1'b0);
    send(1'b1);
    send(1'b0);
    chk("t4_in_post", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t4_rst_busy", 32'(busy), 32'd0);
    chk("t4_rst_trig", 32'(triggered), 32'd0);
    chk("t4_rst_taddr", 32'(trig_addr), 32'd0);
    chk("t4_rst_done", 32'(done), 32'd0);

    // restart after reset (wr_ptr back to 0), then arm during POST with a coincident sample
    do_arm(4'd2, 4'd2);
    send(1'b0);
    send(1'b0);
    send(1'b1);
    chk("t5_taddr", 32'(trig_addr), 32'd2);
    send(1'b0);
    arm = 1'b1; pre_len = 4'd2; post_len = 4'd1;
    in_valid = 1'b1; in_data = dcnt; trig = 1'b1;
    tick();
    arm = 1'b0; in_valid = 1'b0; trig = 1'b0;
    dcnt = dcnt + 16'd1;
    chk("t5_rearm_trig", 32'(triggered), 32'd0);
    chk("t5_rearm_busy", 32'(busy), 32'd1);
    send(1'b0);
    send(1'b0);
    send(1'b1);
    chk("t5_taddr2", 32'(trig_addr), 32'd7);
    send(1'b0);
    chk("t5_done", 32'(done), 32'd1);
    readout(16'd47, 4, 1'b1, 1'b0, 1'b1);
    chk("t5_arm_ign_busy", 32'(busy), 32'd0);
    chk("t5_arm_ign_trig", 32'(triggered), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
